// File: rtl/jk_excitation_sequencer.sv
// ---------------------------------------------------------------------------
// jk_excitation_sequencer
//
// Purpose:
//   Steps a WIDTH-bit bank of JK cells through a programmed table of target
//   states. Each step it derives the J/K excitation that moves the bank from
//   its current state q to table[ptr] (the inverse of the JK characteristic
//   equation), applies that excitation to the internal JK register, and
//   exports J, K and Q. All state changes happen on the falling edge of clk.
//
// Ports:
//   clk        clock; every register updates on the falling edge
//   reset_n    synchronous active-low reset, sampled on the falling edge
//   wr_en      table write strobe (accepted in IDLE/DONE only)
//   wr_addr    table write address
//   wr_data    table write data (target state)
//   wr_last    with wr_en: also mark wr_addr as the last entry
//   start      begin/restart the sequence from entry 0
//   stop       abort the sequence and return to IDLE (beats start)
//   loop       1: wrap to entry 0 after the last entry, 0: stop in DONE
//   j_out      J excitation for the current step (0 outside RUN)
//   k_out      K excitation for the current step (0 outside RUN)
//   q          current state of the JK bank (registered)
//   q_         ~q
//   busy       1 while in RUN (registered)
//   done       1 while in DONE (registered)
//   wr_err     one-cycle pulse after a write attempted in RUN
//   state_dbg  current FSM state: 0 IDLE, 1 RUN, 2 DONE
//
// Handshake: there is no valid/ready pair. A control input is acted on when
// it is high at a falling edge; per edge the priority is
// reset > stop > start > step, and a table write lands on the same edge as
// any start so the first step after that start sees the new contents.
// ---------------------------------------------------------------------------
module jk_excitation_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_last,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [WIDTH-1:0]  tbl [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_idx;
  logic [WIDTH-1:0]  target;
  logic              at_last;
  logic              step_en;
  logic              wr_ok;
  logic              restart;

  assign target    = tbl[ptr];
  assign at_last   = (ptr == last_idx);
  assign state_dbg = state;
  assign q_        = ~q;

  // A step is taken only in RUN on an edge with neither stop nor start;
  // both of those pre-empt the step for that edge.
  assign step_en = (state == S_RUN) && !stop && !start;
  assign restart = start && !stop;
  assign wr_ok   = wr_en && (state != S_RUN);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (stop)       next_state = S_IDLE;
        else if (start) next_state = S_RUN;
      end
      S_RUN: begin
        if (stop)                 next_state = S_IDLE;
        else if (start)           next_state = S_RUN;
        else if (at_last && !loop) next_state = S_DONE;
      end
      S_DONE: begin
        if (stop)       next_state = S_IDLE;
        else if (start) next_state = S_RUN;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: JK excitation. Bits that already match the target get
  // J=K=0 (the don't-care resolved to hold), so the bank only moves in RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == S_RUN) begin
      j_out = ~q & target;
      k_out = q & ~target;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: JK bank, sequence pointer, table, registered flags
  // -------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      q        <= '0;
      ptr      <= '0;
      last_idx <= ADDR_W'(DEPTH - 1);
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      busy   <= (next_state == S_RUN);
      done   <= (next_state == S_DONE);
      wr_err <= wr_en && (state == S_RUN);

      if (wr_ok) begin
        tbl[wr_addr] <= wr_data;
        if (wr_last) begin
          last_idx <= wr_addr;
        end
      end

      // JK characteristic equation applied to the excitation computed above.
      if (step_en) begin
        q <= (q & ~k_out) | (~q & j_out);
      end

      if (restart) begin
        ptr <= '0;
      end else if (step_en) begin
        if (at_last) begin
          if (loop) ptr <= '0;
        end else begin
          ptr <= ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
module tb_jk_excitation_sequencer;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  // ---------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_last;
  logic              start;
  logic              stop;
  logic              loop;
  logic [WIDTH-1:0]  j_out;
  logic [WIDTH-1:0]  k_out;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  jk_excitation_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .j_out    (j_out),
    .k_out    (k_out),
    .q        (q),
    .q_       (q_),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] e_q,
                           input logic [3:0] e_j, input logic [3:0] e_k,
                           input logic e_busy, input logic e_done,
                           input logic e_err);
    check({name, ".q"},      q,               e_q);
    check({name, ".q_"},     q_,              ~e_q);
    check({name, ".j"},      j_out,           e_j);
    check({name, ".k"},      k_out,           e_k);
    check({name, ".busy"},   {3'b000, busy},  {3'b000, e_busy});
    check({name, ".done"},   {3'b000, done},  {3'b000, e_done});
    check({name, ".wr_err"}, {3'b000, wr_err}, {3'b000, e_err});
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks: inputs change just after the rising edge, the DUT acts on
  // the falling edge, outputs are sampled at the next rising edge.
  // ---------------------------------------------------------------------
  task automatic drive(input logic r, input logic we, input logic [2:0] a,
                       input logic [3:0] d, input logic wl, input logic s,
                       input logic sp, input logic lp);
    reset_n = r;  wr_en = we;  wr_addr = a;  wr_data = d;  wr_last = wl;
    start   = s;  stop  = sp;  loop    = lp;
    @(negedge clk);
    @(posedge clk);
  endtask

  // idle cycle with a given loop setting
  task automatic idle(input logic lp);
    drive(1, 0, 0, 0, 0, 0, 0, lp);
  endtask

  typedef struct {
    string      name;
    logic       rst_n;
    logic       we;
    logic [2:0] addr;
    logic [3:0] data;
    logic       last;
    logic       st;
    logic       sp;
    logic       lp;
    logic [3:0] e_q;
    logic [3:0] e_j;
    logic [3:0] e_k;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic we, logic [2:0] a,
                              logic [3:0] d, logic wl, logic s, logic sp,
                              logic lp, logic [3:0] eq, logic [3:0] ej,
                              logic [3:0] ek, logic eb, logic ed, logic ee);
    vec_t v;
    v.name = n;   v.rst_n = r;  v.we = we;  v.addr = a;  v.data = d;
    v.last = wl;  v.st = s;     v.sp = sp;  v.lp = lp;
    v.e_q = eq;   v.e_j = ej;   v.e_k = ek;
    v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  logic [3:0] seq [4];
  logic [3:0] eq_v;
  logic [3:0] et_v;

  initial begin
    reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_last = 0;
    start = 0; stop = 0; loop = 0;
    @(posedge clk);

    //             name        rst we ad  dat lst st sp lp   q     j     k   b d e
    vecs.push_back(mk("reset",   0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr0",     1, 1, 0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr1",     1, 1, 1, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr2",     1, 1, 2, 4'h3, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr3last", 1, 1, 3, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk("t1_start",1, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, 0));
    vecs.push_back(mk("t1_e1",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h1, 4'h2, 4'h1, 1, 0, 0));
    vecs.push_back(mk("t1_e2",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h2, 4'h1, 4'h0, 1, 0, 0));
    vecs.push_back(mk("t1_e3",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h3, 4'h0, 4'h3, 1, 0, 0));
    vecs.push_back(mk("t1_e4",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0));
    vecs.push_back(mk("t2_wr0",  1, 1, 0, 4'h5, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0));
    vecs.push_back(mk("t2_wr1",  1, 1, 1, 4'h9, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0));
    vecs.push_back(mk("t2_start",1, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h5, 4'h0, 1, 0, 0));
    vecs.push_back(mk("t2_s1",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h5, 4'h8, 4'h4, 1, 0, 0));
    vecs.push_back(mk("t2_s2",   1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h9, 4'h0, 4'h0, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].data,
            vecs[i].last, vecs[i].st, vecs[i].sp, vecs[i].lp);
      check_all(vecs[i].name, vecs[i].e_q, vecs[i].e_j, vecs[i].e_k,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end

    // Test 3: restore table 1,2,3,0 (last=3) and loop for 10 steps
    drive(1, 1, 0, 4'h1, 0, 0, 0, 1);
    drive(1, 1, 1, 4'h2, 0, 0, 0, 1);
    drive(1, 1, 3, 4'h0, 1, 0, 0, 1);
    check_all("t3_wr", 4'h9, 4'h0, 4'h0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    check_all("t3_start", 4'h9, 4'h0, 4'h8, 1, 0, 0);
    seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3; seq[3] = 4'h0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      eq_v = seq[i % 4];
      et_v = seq[(i + 1) % 4];
      check_all($sformatf("t3_step%0d", i), eq_v, ~eq_v & et_v, eq_v & ~et_v,
                1, 0, 0);
    end

    // Test 4: restart, stop after two steps, then replay from entry 0
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    check_all("t4_start", 4'h2, 4'h1, 4'h2, 1, 0, 0);
    idle(0);
    check_all("t4_s1", 4'h1, 4'h2, 4'h1, 1, 0, 0);
    idle(0);
    check_all("t4_s2", 4'h2, 4'h1, 4'h0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    check_all("t4_stop", 4'h2, 4'h0, 4'h0, 0, 0, 0);
    check("t4_state", {2'b00, state_dbg}, 4'h0);
    idle(0);
    check_all("t4_hold", 4'h2, 4'h0, 4'h0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    check_all("t4_restart", 4'h2, 4'h1, 4'h2, 1, 0, 0);
    idle(0);
    check_all("t4_replay", 4'h1, 4'h2, 4'h1, 1, 0, 0);

    // Test 5: write in RUN is dropped, wr_err pulses for one cycle
    drive(1, 1, 1, 4'hF, 0, 0, 0, 0);
    check_all("t5_wr_run", 4'h2, 4'h1, 4'h0, 1, 0, 1);
    idle(0);
    check_all("t5_err_clr", 4'h3, 4'h0, 4'h3, 1, 0, 0);
    idle(0);
    check_all("t5_done", 4'h0, 4'h0, 4'h0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    check_all("t5_start", 4'h0, 4'h1, 4'h0, 1, 0, 0);
    idle(0);
    check_all("t5_s1", 4'h1, 4'h2, 4'h1, 1, 0, 0);
    idle(0);
    check_all("t5_tbl1_kept", 4'h2, 4'h1, 4'h0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    check_all("t5_start_stop", 4'h2, 4'h0, 4'h0, 0, 0, 0);

    // Test 6: reset mid-RUN with q=3
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    check_all("t6_start", 4'h2, 4'h1, 4'h2, 1, 0, 0);
    idle(1);
    idle(1);
    idle(1);
    check_all("t6_q3", 4'h3, 4'h0, 4'h3, 1, 0, 0);
    reset_n = 0;
    #1;
    check_all("t6_no_async", 4'h3, 4'h0, 4'h3, 1, 0, 0);
    @(negedge clk);
    @(posedge clk);
    check_all("t6_reset", 4'h0, 4'h0, 4'h0, 0, 0, 0);
    check("t6_state", {2'b00, state_dbg}, 4'h0);
    // cleared table and last_idx=DEPTH-1: eight zero steps, then DONE
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    check_all("t6_start2", 4'h0, 4'h0, 4'h0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      idle(0);
      check_all($sformatf("t6_zero%0d", i), 4'h0, 4'h0, 4'h0,
                (i != DEPTH - 1), (i == DEPTH - 1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
